// File: rtl/image_serial_tx.sv
// Frame transmitter: scans frame memory in raster order and sends each 16-bit
// pixel as two UART 8N1 bytes, MSB byte first.
module image_serial_tx #(
    parameter int LINES        = 120,
    parameter int COLUMNS      = 320,
    parameter int S_DATA       = 16,
    parameter int S_LINE       = 7,
    parameter int S_COLUMN     = 9,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    output logic [S_LINE-1:0]   mem_linha,
    output logic [S_COLUMN-1:0] mem_coluna,
    output logic                mem_re,
    input  logic [S_DATA-1:0]   mem_dado,
    output logic                saida_serial,
    output logic                ocupado,
    output logic                fim_transmissao,
    output logic [S_DATA-1:0]   db_pixel,
    output logic [3:0]          db_estado
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [S_LINE-1:0]   LINE_LAST = S_LINE'(LINES - 1);
    localparam logic [S_COLUMN-1:0] COL_LAST  = S_COLUMN'(COLUMNS - 1);
    localparam int HALF = S_DATA / 2;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        LE_MEM     = 4'd1,
        ESPERA_MEM = 4'd2,
        ENVIA_MSB  = 4'd3,
        ESPERA_MSB = 4'd4,
        ENVIA_LSB  = 4'd5,
        ESPERA_LSB = 4'd6,
        PROXIMO    = 4'd7,
        FIM        = 4'd8
    } state_t;

    state_t              state_reg, state_next;
    logic [S_LINE-1:0]   line_reg, line_next;
    logic [S_COLUMN-1:0] col_reg, col_next;
    logic [S_DATA-1:0]   pixel_reg, pixel_next;

    logic                uart_start;
    logic                send_msb;
    logic [7:0]          uart_byte;
    logic                uart_done;

    logic                tx_busy_reg;
    logic [3:0]          bit_idx_reg;
    logic [BAUD_W-1:0]   baud_reg;
    logic [7:0]          shift_reg;
    logic                tx_reg;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= INICIAL;
            line_reg  <= '0;
            col_reg   <= '0;
            pixel_reg <= '0;
        end else begin
            state_reg <= state_next;
            line_reg  <= line_next;
            col_reg   <= col_next;
            pixel_reg <= pixel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        line_next  = line_reg;
        col_next   = col_reg;
        pixel_next = pixel_reg;
        mem_re     = 1'b0;
        uart_start = 1'b0;
        send_msb   = 1'b0;
        case (state_reg)
            INICIAL: begin
                if (iniciar) begin
                    state_next = LE_MEM;
                end
            end
            LE_MEM: begin
                mem_re     = 1'b1;
                state_next = ESPERA_MEM;
            end
            ESPERA_MEM: begin
                pixel_next = mem_dado;
                state_next = ENVIA_MSB;
            end
            ENVIA_MSB: begin
                uart_start = 1'b1;
                send_msb   = 1'b1;
                state_next = ESPERA_MSB;
            end
            ESPERA_MSB: begin
                if (uart_done) begin
                    state_next = ENVIA_LSB;
                end
            end
            ENVIA_LSB: begin
                uart_start = 1'b1;
                state_next = ESPERA_LSB;
            end
            ESPERA_LSB: begin
                if (uart_done) begin
                    state_next = PROXIMO;
                end
            end
            PROXIMO: begin
                // The last pixel leaves the address untouched; FIM clears it.
                if (line_reg == LINE_LAST && col_reg == COL_LAST) begin
                    state_next = FIM;
                end else begin
                    if (col_reg < COL_LAST) begin
                        col_next = col_reg + 1'b1;
                    end else begin
                        col_next  = '0;
                        line_next = line_reg + 1'b1;
                    end
                    state_next = LE_MEM;
                end
            end
            FIM: begin
                line_next  = '0;
                col_next   = '0;
                state_next = INICIAL;
            end
            default: begin
                state_next = INICIAL;
            end
        endcase
    end

    // Byte selection: upper half for the MSB request, lower half otherwise.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_sel
            assign uart_byte[gi] = send_msb ? pixel_reg[HALF + gi] : pixel_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // UART 8N1 shifter. bit_idx 0 = start, 1..8 = data, 9 = stop.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_busy_reg <= 1'b0;
            bit_idx_reg <= '0;
            baud_reg    <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else if (uart_start) begin
            tx_busy_reg <= 1'b1;
            bit_idx_reg <= '0;
            baud_reg    <= '0;
            shift_reg   <= uart_byte;
            tx_reg      <= 1'b0;
        end else if (tx_busy_reg) begin
            if (baud_reg == BAUD_LAST) begin
                baud_reg <= '0;
                if (bit_idx_reg == 4'd9) begin
                    tx_busy_reg <= 1'b0;
                    tx_reg      <= 1'b1;
                end else begin
                    bit_idx_reg <= bit_idx_reg + 4'd1;
                    if (bit_idx_reg == 4'd8) begin
                        tx_reg <= 1'b1;
                    end else begin
                        tx_reg    <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end
                end
            end else begin
                baud_reg <= baud_reg + 1'b1;
            end
        end
    end

    // Done coincides with the final stop-bit cycle so the next request lands
    // right after the stop bit ends.
    assign uart_done = tx_busy_reg && (bit_idx_reg == 4'd9) && (baud_reg == BAUD_LAST);

    assign saida_serial    = tx_reg;
    assign mem_linha       = line_reg;
    assign mem_coluna      = col_reg;
    assign ocupado         = (state_reg != INICIAL);
    assign fim_transmissao = (state_reg == FIM);
    assign db_pixel        = pixel_reg;
    assign db_estado       = state_reg;

endmodule

// File: tb/tb_image_serial_tx.sv
// Directed bench for image_serial_tx on a 2x3 frame at 4 clocks per bit.
module tb_image_serial_tx;

    localparam int LINES    = 2;
    localparam int COLUMNS  = 3;
    localparam int CPB      = 4;
    localparam int NBYTES   = LINES * COLUMNS * 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic [6:0]  mem_linha;
    logic [8:0]  mem_coluna;
    logic        mem_re;
    logic [15:0] mem_dado = '0;
    logic        saida_serial;
    logic        ocupado;
    logic        fim_transmissao;
    logic [15:0] db_pixel;
    logic [3:0]  db_estado;

    image_serial_tx #(
        .LINES(LINES), .COLUMNS(COLUMNS), .S_DATA(16),
        .S_LINE(7), .S_COLUMN(9), .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .mem_linha(mem_linha), .mem_coluna(mem_coluna), .mem_re(mem_re),
        .mem_dado(mem_dado), .saida_serial(saida_serial), .ocupado(ocupado),
        .fim_transmissao(fim_transmissao), .db_pixel(db_pixel), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:1][0:3];
    always @(posedge clock) begin
        if (mem_re) mem_dado <= mem[mem_linha[0]][mem_coluna[1:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART / memory-port monitor, sampled on the falling edge
    logic [7:0] q_bytes[$];
    int         q_gaps[$];
    logic [9:0] q_seq[$];
    int width_err, rd_cnt, rd_err, fim_cnt;

    initial begin : monitor
        logic [39:0] samp;
        logic [9:0]  seq;
        int  mon_cnt;
        int  mon_gap;
        bit  mon_active;
        samp = '0; mon_cnt = 0; mon_gap = 0; mon_active = 0;
        forever begin
            @(negedge clock);
            if (reset && mem_re) begin
                if (mem_linha != 7'(rd_cnt / COLUMNS) || mem_coluna != 9'(rd_cnt % COLUMNS))
                    rd_err++;
                rd_cnt++;
            end
            if (reset && fim_transmissao) fim_cnt++;
            if (!reset) begin
                mon_active = 0; mon_cnt = 0; mon_gap = 0;
            end else if (!mon_active) begin
                if (saida_serial == 1'b0) begin
                    mon_active = 1; samp[0] = 1'b0; mon_cnt = 1;
                end else begin
                    mon_gap++;
                end
            end else begin
                samp[mon_cnt] = saida_serial;
                mon_cnt++;
                if (mon_cnt == 10 * CPB) begin
                    for (int g = 0; g < 10; g++) begin
                        seq[g] = samp[CPB*g];
                        if (samp[CPB*g +: CPB] != {CPB{samp[CPB*g]}}) width_err++;
                    end
                    if (seq[9] !== 1'b1) width_err++;
                    q_bytes.push_back(seq[8:1]);
                    q_gaps.push_back(mon_gap);
                    q_seq.push_back(seq);
                    mon_active = 0; mon_gap = 0; mon_cnt = 0;
                end
            end
        end
    end

    logic [7:0] exp_bytes [NBYTES];

    task automatic clear_mon();
        q_bytes.delete(); q_gaps.delete(); q_seq.delete();
        width_err = 0; rd_cnt = 0; rd_err = 0; fim_cnt = 0;
    endtask

    // Starts one frame and waits for its end pulse; optional iniciar spam
    // during the frame and an iniciar coinciding with the FIM cycle.
    task automatic run_frame(input bit spam, input bit start_at_fim);
        bit done;
        done = 0;
        clear_mon();
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clock);
            if (fim_transmissao) begin
                done = 1;
                check("ocupado_at_fim", 32'(ocupado), 32'd1);
                iniciar = start_at_fim;
                @(posedge clock); #1;
                iniciar = 1'b0;
                @(negedge clock);
                check("ocupado_after_fim", 32'(ocupado), 32'd0);
                check("estado_after_fim", 32'(db_estado), 32'd0);
            end else begin
                iniciar = spam && (c % 37 == 5);
            end
        end
        iniciar = 1'b0;
        if (!done) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic verify_frame(input string tag);
        check({tag, "_nbytes"}, 32'(q_bytes.size()), 32'(NBYTES));
        for (int i = 0; i < NBYTES; i++) begin
            if (i < q_bytes.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(q_bytes[i]), 32'(exp_bytes[i]));
                if (i > 0)
                    check($sformatf("%s_gap%0d", tag, i), 32'(q_gaps[i]), (i % 2 == 1) ? 32'd1 : 32'd4);
            end
        end
        check({tag, "_bitwidth"}, 32'(width_err), 32'd0);
        check({tag, "_reads"}, 32'(rd_cnt), 32'(LINES * COLUMNS));
        check({tag, "_addr_order"}, 32'(rd_err), 32'd0);
        check({tag, "_fim_pulses"}, 32'(fim_cnt), 32'd1);
    endtask

    initial begin
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 4; c++)
                mem[l][c] = {8'(l), 8'(c)};
        exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02,
                      8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02};
        clear_mon();

        // Reset and idle
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (30) @(negedge clock);
        check("idle_line", 32'(saida_serial), 32'd1);
        check("idle_ocupado", 32'(ocupado), 32'd0);
        check("idle_estado", 32'(db_estado), 32'd0);
        check("idle_mem_re_count", 32'(rd_cnt), 32'd0);
        check("idle_pixel", 32'(db_pixel), 32'd0);
        check("idle_fim", 32'(fim_transmissao), 32'd0);
        $display("idle: line=%0b ocupado=%0b estado=%0d", saida_serial, ocupado, db_estado);

        // Single frame
        run_frame(1'b0, 1'b0);
        verify_frame("single");
        $display("single frame: %0d bytes", q_bytes.size());

        // Busy protection plus iniciar in the FIM cycle
        run_frame(1'b1, 1'b1);
        verify_frame("busy");
        repeat (5) @(negedge clock);
        check("fim_start_ignored", 32'(ocupado), 32'd0);
        $display("busy frame: %0d bytes", q_bytes.size());

        // Back-to-back frames
        run_frame(1'b0, 1'b0);
        verify_frame("b2b_first");
        run_frame(1'b0, 1'b0);
        verify_frame("b2b_second");
        $display("back-to-back: %0d bytes in second frame", q_bytes.size());

        // Bit order with pixel 0xA55A at (0,0): A5 and 5A on the line, LSB first
        mem[0][0] = 16'hA55A;
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = 8'h5A;
        run_frame(1'b0, 1'b0);
        verify_frame("bitorder");
        if (q_seq.size() >= 2) begin
            check("bitorder_seq_msb", 32'(q_seq[0]), 32'(10'b1101001010));
            check("bitorder_seq_lsb", 32'(q_seq[1]), 32'(10'b1010110100));
        end else begin
            check("bitorder_seq_count", 32'(q_seq.size()), 32'd2);
        end
        $display("bit order: first byte %0h second byte %0h",
                 (q_bytes.size() > 0) ? q_bytes[0] : 8'h00,
                 (q_bytes.size() > 1) ? q_bytes[1] : 8'h00);
        mem[0][0] = 16'h0000;
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'h00;

        // Reset during data bit 3 of the fifth byte (pixel (0,2) MSB = 0x00)
        begin
            bit hit;
            hit = 0;
            clear_mon();
            iniciar = 1'b1;
            @(posedge clock); #1;
            iniciar = 1'b0;
            for (int c = 0; c < 5000 && !hit; c++) begin
                @(negedge clock); #1;
                if (q_bytes.size() == 4 && saida_serial == 1'b0 && dut.bit_idx_reg == 4'd4)
                    hit = 1;
            end
            check("reset_point_reached", 32'(hit), 32'd1);
            check("line_low_before_reset", 32'(saida_serial), 32'd0);
            reset = 1'b0;
            #1;
            check("reset_line_high", 32'(saida_serial), 32'd1);
            check("reset_ocupado", 32'(ocupado), 32'd0);
            check("reset_estado", 32'(db_estado), 32'd0);
            check("reset_addr", 32'({mem_linha, mem_coluna}), 32'd0);
            repeat (2) @(posedge clock);
            #1 reset = 1'b1;
            repeat (3) @(negedge clock);
            run_frame(1'b0, 1'b0);
            verify_frame("after_reset");
            $display("after reset: %0d bytes, first %0h %0h", q_bytes.size(),
                     (q_bytes.size() > 0) ? q_bytes[0] : 8'h00,
                     (q_bytes.size() > 1) ? q_bytes[1] : 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
